// File: rtl/bf8b_pkg.sv
// Shared bf8b pipeline definitions: register-file defaults, RV32 opcodes,
// memory access sizes and the opcode-to-register-usage decode.
package bf8b_pkg;

  localparam int unsigned DEFAULT_REG_CNT        = 32;
  localparam int unsigned DEFAULT_REG_ADDR_WIDTH = $clog2(DEFAULT_REG_CNT);

  typedef enum logic [6:0] {
    OP_LOAD        = 7'b0000011,
    OP_INTEGER_IMM = 7'b0010011,
    OP_AUIPC       = 7'b0010111,
    OP_STORE       = 7'b0100011,
    OP_INTEGER_REG = 7'b0110011,
    OP_LUI         = 7'b0110111,
    OP_BRANCH      = 7'b1100011,
    OP_JALR        = 7'b1100111,
    OP_JAL         = 7'b1101111
  } opcode_t;

  typedef enum logic [1:0] {
    MEM_ACC_BYTE = 2'b00,
    MEM_ACC_HALF = 2'b01,
    MEM_ACC_WORD = 2'b10
  } mem_acc_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } reg_use_t;

  // Which operands an opcode reads and whether it produces rd.
  function automatic reg_use_t decode_reg_use(input logic [6:0] opcode);
    reg_use_t u;
    u = '0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        u.writes_rd = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_INTEGER_IMM: begin
        u.uses_rs1  = 1'b1;
        u.writes_rd = 1'b1;
      end
      OP_INTEGER_REG: begin
        u.uses_rs1  = 1'b1;
        u.uses_rs2  = 1'b1;
        u.writes_rd = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
      end
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One register's pending-write counter: saturating up/down with clear,
// reporting busy, full and an attempted decrement below zero.
module sb_entry
  import bf8b_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic busy,
  output logic full,
  output logic underflow
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Simultaneous inc and dec cancel, including at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && !dec && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_WIDTH'(1);
    end
  end

  assign busy      = (cnt_q != '0);
  assign full      = (cnt_q == '1);
  assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/scoreboard.sv
// Register-dependency scoreboard: tracks in-flight register writes between
// execute issue and writeback retire and gates decode-to-execute start.
module scoreboard
  import bf8b_pkg::*;
#(
  parameter int unsigned REG_CNT        = DEFAULT_REG_CNT,
  parameter int unsigned REG_ADDR_WIDTH = $clog2(REG_CNT),
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned MAX_INFLIGHT   = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]         issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]         issue_rs2,
  input  logic                              issue_uses_rs1,
  input  logic                              issue_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]         issue_rd,
  input  logic                              issue_writes_rd,
  output logic                              issue_ready,
  input  logic                              retire_valid,
  input  logic [REG_ADDR_WIDTH-1:0]         retire_rd,
  input  logic                              retire_wrote,
  input  logic                              flush,
  output logic [REG_CNT-1:0]                busy_regs,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err
);

  localparam int unsigned INFL_WIDTH = $clog2(MAX_INFLIGHT + 1);

  logic [REG_CNT-1:0]    rd_full;
  logic [REG_CNT-1:0]    underflow;
  logic [REG_CNT-1:1]    inc_vec;
  logic [REG_CNT-1:1]    dec_vec;
  logic [INFL_WIDTH-1:0] inflight_q;
  logic                  err_q;
  logic                  hazard;
  logic                  slot_free;
  logic                  rd_blocked;
  logic                  issue_fire;
  logic                  retire_illegal;

  // Readiness looks only at registered state and the issue_* operands.
  always_comb begin
    hazard     = (issue_uses_rs1 && busy_regs[issue_rs1]) ||
                 (issue_uses_rs2 && busy_regs[issue_rs2]);
    slot_free  = (inflight_q < INFL_WIDTH'(MAX_INFLIGHT));
    rd_blocked = issue_writes_rd && rd_full[issue_rd];
    issue_ready = !hazard && slot_free && !rd_blocked;
  end

  assign issue_fire = issue_valid && issue_ready;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 1; i < REG_CNT; i++) begin
      inc_vec[i] = issue_fire && issue_writes_rd && (issue_rd == REG_ADDR_WIDTH'(i));
      dec_vec[i] = retire_valid && retire_wrote && (retire_rd == REG_ADDR_WIDTH'(i));
    end
  end

  assign busy_regs[0] = 1'b0;
  assign rd_full[0]   = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar i = 1; i < REG_CNT; i++) begin : g_entry
    sb_entry #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[i]),
      .dec       (dec_vec[i]),
      .clr       (flush),
      .busy      (busy_regs[i]),
      .full      (rd_full[i]),
      .underflow (underflow[i])
    );
  end

  assign retire_illegal = retire_valid && ((inflight_q == '0) || (|underflow));

  // Flush drops any same-cycle issue/retire, so it also masks their errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (flush) begin
        inflight_q <= '0;
      end else if (issue_fire && !retire_valid) begin
        inflight_q <= inflight_q + INFL_WIDTH'(1);
      end else if (!issue_fire && retire_valid && inflight_q != '0) begin
        inflight_q <= inflight_q - INFL_WIDTH'(1);
      end
      if (!flush && retire_illegal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign inflight = inflight_q;
  assign err      = err_q;

endmodule

// File: doc/scoreboard.md
# scoreboard

Register-dependency scoreboard for the bf8b in-order RV32 pipeline. It tracks every architectural register with a write still in flight between execute issue and writeback retire. It drives the decode-to-execute start condition, so an instruction enters execute only when its source operands are final. With it in place, execute start no longer has to rely on writeback finishing in one cycle.

## Interface
Parameters:
- REG_CNT, 32, number of architectural registers; x0 is never tracked.
- REG_ADDR_WIDTH, $clog2(REG_CNT), register address width.
- CNT_WIDTH, 2, width of each per-register pending counter; maximum value is 2^CNT_WIDTH-1.
- MAX_INFLIGHT, 3, maximum number of issued, unretired instructions.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode holds an instruction ready to enter execute.
- issue_rs1, issue_rs2  in  REG_ADDR_WIDTH  source register addresses.
- issue_uses_rs1, issue_uses_rs2  in  1  the operand is actually read (from the opcode).
- issue_rd  in  REG_ADDR_WIDTH  destination register.
- issue_writes_rd  in  1  the instruction writes rd (LUI/AUIPC/JAL/JALR/LOAD/INTEGER*).
- issue_ready  out  1  combinational; issue is permitted this cycle.
- retire_valid  in  1  writeback completes one instruction this cycle.
- retire_rd  in  REG_ADDR_WIDTH  destination of the retiring instruction.
- retire_wrote  in  1  the retiring instruction wrote rd; 0 for stores, branches, and squashed instructions.
- flush  in  1  discard all in-flight tracking (pipeline flush of issued work).
- busy_regs  out  REG_CNT  registered; bit i set when register i has a pending write.
- inflight  out  $clog2(MAX_INFLIGHT+1)  registered count of issued, unretired instructions.
- err  out  1  sticky; set on an illegal retire.

## Operation
- State per register i in 1..REG_CNT-1: pending counter pc_i of CNT_WIDTH bits. Register 0 has no counter and busy_regs[0] is always 0.
- busy_regs[i] = (pc_i != 0).
- A hazard exists when either of these holds:
  - issue_uses_rs1 and busy_regs[issue_rs1] is set;
  - issue_uses_rs2 and busy_regs[issue_rs2] is set.
- issue_ready is high only when all of these hold:
  - no hazard;
  - inflight < MAX_INFLIGHT;
  - when issue_writes_rd and issue_rd != 0: pc_rd is below its maximum value.
- issue_ready is computed from registered state only. There is no same-cycle retire bypass.
- Issue fires when issue_valid && issue_ready:
  - inflight increments;
  - pc_rd increments when issue_writes_rd and rd != 0.
- Retire fires when retire_valid:
  - inflight decrements;
  - pc_retire_rd decrements when retire_wrote and retire_rd != 0.
- Illegal retire: inflight == 0, or a decrement of a counter already at 0.
  - The affected counter stays at 0; inflight stays at 0.
  - err is set and holds until rst.
- Issue and retire in the same cycle:
  - inflight is unchanged.
  - If both touch the same register, that counter is unchanged (net 0).
- flush:
  - All counters and inflight go to 0 next cycle.
  - Any issue or retire in the same cycle is ignored.
  - err is preserved.
- Reset values:
  - busy_regs = 0, inflight = 0, err = 0.
  - issue_ready = 1 whenever the inputs present no conflict (state is empty).
- Reset mid-operation clears all state; any in-flight retire arriving afterwards is the controller's responsibility to suppress.

## Timing
- issue_ready has combinational dependence on the issue_* address and flag inputs only, never on issue_valid or retire_*.
- Issue at edge N: busy_regs reflects it after edge N. A dependent instruction sees issue_ready = 0 from cycle N+1.
- Retire at edge N: the hazard clears in cycle N+1. The minimum producer-to-consumer gap is therefore one cycle after retire.
- flush at edge N: busy_regs = 0 and issue_ready = 1 from cycle N+1.
- No internal latency beyond one register stage; throughput is one issue plus one retire per cycle.

## Structure
- Shared package bf8b_pkg holds:
  - REG_CNT and REG_ADDR_WIDTH defaults;
  - the OP_* opcode constants, which the controller uses to derive issue_uses_rs* and issue_writes_rd;
  - MEM_ACC_* constants.
- Sub-module sb_entry implements one saturating up/down counter with inc, dec, and clr inputs and a busy output. It flags an underflow to the parent. The parent instantiates one per register 1..REG_CNT-1 via generate.
- The top level holds the inflight counter, the hazard/ready logic and the err flag.

## Test plan
- Reset, then issue rd=5 (writes), then issue with rs1=5:
  - busy_regs = 0x20 after the first issue;
  - issue_ready = 0 for the second until retire rd=5;
  - issue_ready = 1 the cycle after retire.
- Issue rd=0 with writes=1, then rs1=0 → busy_regs stays 0 and issue_ready stays 1.
- Three issues to rd=7, 8, 9 → inflight = 3 and issue_ready = 0 for an independent instruction. One retire → issue_ready = 1 the next cycle.
- Two issues to rd=3 (pc_3 = 2), then retire rd=3 in the same cycle as a third issue to rd=3:
  - pc_3 stays 2;
  - busy_regs[3] stays set until two more retires.
- flush with 3 in flight, plus a simultaneous issue → inflight = 0, busy_regs = 0, err unchanged.
- Retire with inflight = 0 → err = 1, inflight stays 0. err persists until rst, which clears it.
